// File: rtl/i2s_sample_tx.sv
// Mono 16-bit sample FIFO feeding an I2S transmitter (SCLK/LRCLK/SDATA generated from CLK).
// Define I2S_UNDERRUN_HOLD_EN to repeat the last popped sample on underrun instead of sending silence.
module i2s_sample_tx #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned SCLK_DIV = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        FIFO_WRITE,
  input  logic [15:0] AUDIO_IN,
  output logic        FIFO_FULL,
  output logic [6:0]  LEVEL,
  output logic        SCLK,
  output logic        LRCLK,
  output logic        SDATA,
  output logic        UNDERRUN
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned DW = 8;
  localparam int unsigned LW = 7;
  localparam int unsigned BW = 5;

  logic [15:0]    mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [DW-1:0]  div_cnt;
  logic [BW-1:0]  bit_idx;
  logic [31:0]    frame;

  logic           tick;
  logic           fall;
  logic           fetch;
  logic           wr_ok;
  logic           pop;
  logic [BW-1:0]  bit_next;
  logic [15:0]    fill;
  logic [15:0]    sample;
  logic [LW-1:0]  level_next;

  // Timing and FIFO handshakes for the current cycle
  always_comb begin
    tick       = (div_cnt == DW'(SCLK_DIV - 1));
    fall       = tick && SCLK;
    bit_next   = bit_idx + BW'(1);
    fetch      = fall && (bit_idx == '0);
    wr_ok      = FIFO_WRITE && !FIFO_FULL && !RESET;
    pop        = fetch && (LEVEL != '0);
    sample     = pop ? mem[rd_ptr] : fill;
    level_next = LW'(LEVEL + LW'(wr_ok) - LW'(pop));
  end

`ifdef I2S_UNDERRUN_HOLD_EN
  logic [15:0] held;

  // Last successfully popped sample, replayed when the FIFO runs dry
  always_ff @(posedge CLK) begin
    if (RESET) begin
      held <= '0;
    end else if (pop) begin
      held <= mem[rd_ptr];
    end
  end

  assign fill = held;
`else
  assign fill = 16'h0000;
`endif

  // Sample storage; contents are irrelevant after reset since pointers restart
  always_ff @(posedge CLK) begin
    if (wr_ok) begin
      mem[wr_ptr] <= AUDIO_IN;
    end
  end

  // Bit clock, word select, serializer and FIFO bookkeeping
  always_ff @(posedge CLK) begin
    if (RESET) begin
      div_cnt   <= '0;
      SCLK      <= 1'b0;
      LRCLK     <= 1'b0;
      SDATA     <= 1'b0;
      UNDERRUN  <= 1'b0;
      bit_idx   <= '0;
      frame     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      LEVEL     <= '0;
      FIFO_FULL <= 1'b0;
    end else begin
      div_cnt  <= tick ? '0 : div_cnt + DW'(1);
      UNDERRUN <= fetch && (LEVEL == '0);
      if (tick) begin
        SCLK <= ~SCLK;
      end
      if (fall) begin
        bit_idx <= bit_next;
        LRCLK   <= bit_next[BW-1];
        if (fetch) begin
          frame <= {sample, sample};
          SDATA <= sample[15];
        end else begin
          // One-bit I2S delay: slot bit B carries frame bit (32-B) mod 32
          SDATA <= frame[BW'(0) - bit_next];
        end
      end
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      LEVEL     <= level_next;
      FIFO_FULL <= (level_next == LW'(DEPTH));
    end
  end

endmodule

// File: tb/tb_i2s_sample_tx.sv
// Bench for i2s_sample_tx: FIFO/frame scoreboard, bit-clock timing monitor, vector table and corner sequences.
module tb_i2s_sample_tx;

  localparam int unsigned DEPTH    = 16;
  localparam int unsigned SCLK_DIV = 2;
`ifdef I2S_UNDERRUN_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        FIFO_WRITE = 1'b0;
  logic [15:0] AUDIO_IN = '0;
  logic        FIFO_FULL;
  logic [6:0]  LEVEL;
  logic        SCLK;
  logic        LRCLK;
  logic        SDATA;
  logic        UNDERRUN;

  i2s_sample_tx #(.DEPTH(DEPTH), .SCLK_DIV(SCLK_DIV)) dut (
    .CLK(CLK), .RESET(RESET), .FIFO_WRITE(FIFO_WRITE), .AUDIO_IN(AUDIO_IN),
    .FIFO_FULL(FIFO_FULL), .LEVEL(LEVEL), .SCLK(SCLK), .LRCLK(LRCLK),
    .SDATA(SDATA), .UNDERRUN(UNDERRUN)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [31:0] frame; logic und; } sb_t;
  typedef struct { logic [15:0] audio; logic [31:0] exp_frame; } vec_t;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] mq[$];
  sb_t         sbq[$];
  int          bcnt = 0;
  int          cyc = 0;
  logic        prev_sclk = 1'b0;
  logic        collecting = 1'b0;
  logic [31:0] shreg = '0;
  logic [15:0] held = '0;
  int          fetches = 0;
  int          data_frames = 0;
  int          all_frames = 0;
  logic [31:0] last_frame = '0;
  logic [31:0] last_data_frame = '0;
  logic        rst_s = 1'b1;
  logic        wr_s = 1'b0;
  logic [15:0] din_s = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic push_word(input logic [15:0] d);
    AUDIO_IN   = d;
    FIFO_WRITE = 1'b1;
    step();
    FIFO_WRITE = 1'b0;
  endtask

  // Inputs as the DUT saw them at the edge
  always @(posedge CLK) begin
    rst_s = RESET;
    wr_s  = FIFO_WRITE;
    din_s = AUDIO_IN;
  end

  // Reference model: I2S bit position, FIFO contents, frame capture
  always @(negedge CLK) begin : mon
    logic        full_before;
    logic        exp_und;
    logic [15:0] s;
    sb_t         sb;
    if (rst_s) begin
      mq.delete();
      sbq.delete();
      bcnt = 0;
      cyc = 0;
      prev_sclk = 1'b0;
      collecting = 1'b0;
      held = '0;
      check("reset_outputs", 32'({SCLK, LRCLK, SDATA, UNDERRUN, FIFO_FULL, LEVEL}), 32'h0);
    end else begin
      cyc++;
      exp_und = 1'b0;
      full_before = (mq.size() == DEPTH);
      if (SCLK !== prev_sclk) begin
        check("sclk_half_period", cyc, SCLK_DIV);
        cyc = 0;
        prev_sclk = SCLK;
        if (SCLK) begin
          check("lrclk_slot", 32'(LRCLK), 32'(bcnt >= 16));
          if (bcnt == 1) begin
            shreg = {31'b0, SDATA};
            collecting = 1'b1;
          end else if (collecting) begin
            shreg = {shreg[30:0], SDATA};
            if (bcnt == 0) begin
              collecting = 1'b0;
              if (sbq.size() == 0) begin
                timeout_fail("frame_without_fetch");
              end else begin
                sb = sbq.pop_front();
                check("frame_data", shreg, sb.frame);
                all_frames++;
                last_frame = shreg;
                if (!sb.und) begin
                  data_frames++;
                  last_data_frame = shreg;
                end
              end
            end
          end
        end else begin
          bcnt = (bcnt + 1) % 32;
          if (bcnt == 1) begin
            fetches++;
            if (mq.size() > 0) begin
              s = mq.pop_front();
              held = s;
            end else begin
              exp_und = 1'b1;
              s = HOLD_EN ? held : 16'h0000;
            end
            sbq.push_back('{frame: {s, s}, und: exp_und});
          end
        end
      end else if (cyc > SCLK_DIV) begin
        check("sclk_stuck", cyc, SCLK_DIV);
        cyc = 0;
      end
      if (wr_s && !full_before) mq.push_back(din_s);
      check("underrun", 32'(UNDERRUN), 32'(exp_und));
      check("level", 32'(LEVEL), 32'(mq.size()));
      check("fifo_full", 32'(FIFO_FULL), 32'(mq.size() == DEPTH));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    vec_t vecs[6];
    int   n;
    int   cnt;
    vecs[0] = '{16'hA5C3, 32'hA5C3A5C3};
    vecs[1] = '{16'h7FFF, 32'h7FFF7FFF};
    vecs[2] = '{16'hFFFF, 32'hFFFFFFFF};
    vecs[3] = '{16'h0001, 32'h00010001};
    vecs[4] = '{16'h0000, 32'h00000000};
    vecs[5] = '{16'h8001, 32'h80018001};

    RESET = 1'b1;
    repeat (3) step();
    RESET = 1'b0;

    // One sample per frame; each must come out as {S,S}
    for (int i = 0; i < 6; i++) begin
      n = data_frames;
      push_word(vecs[i].audio);
      cnt = 0;
      while (data_frames == n && cnt < 600) begin step(); cnt++; end
      if (data_frames == n) timeout_fail("vec_wait");
      else check("vec_frame", last_data_frame, vecs[i].exp_frame);
    end

    // Empty FIFO after 8001: underrun frame
    n = all_frames;
    cnt = 0;
    while (all_frames == n && cnt < 400) begin step(); cnt++; end
    if (all_frames == n) timeout_fail("underrun_wait");
    else check("underrun_frame", last_frame, HOLD_EN ? 32'h80018001 : 32'h00000000);

    // Fill right after a fetch: 20 writes, last 4 dropped
    n = fetches;
    cnt = 0;
    while (fetches == n && cnt < 300) begin step(); cnt++; end
    if (fetches == n) timeout_fail("fill_sync");
    for (int i = 0; i < 20; i++) begin
      AUDIO_IN   = 16'h1000 + 16'(i);
      FIFO_WRITE = 1'b1;
      step();
      if (i == 15) check("full_after_16", 32'({FIFO_FULL, LEVEL}), 32'({1'b1, 7'd16}));
    end
    FIFO_WRITE = 1'b0;
    check("full_after_20", 32'({FIFO_FULL, LEVEL}), 32'({1'b1, 7'd16}));

    // Write coincident with the fetch pop while full
    cnt = 0;
    while (!(prev_sclk && bcnt == 0 && cyc == SCLK_DIV - 1) && cnt < 300) begin step(); cnt++; end
    if (cnt >= 300) timeout_fail("prefetch_sync");
    n = data_frames;
    push_word(16'hDEAD);
    check("full_pop_level", 32'({FIFO_FULL, LEVEL}), 32'({1'b0, 7'd15}));
    cnt = 0;
    while (data_frames < n + 16 && cnt < 2600) begin step(); cnt++; end
    if (data_frames < n + 16) timeout_fail("drain_wait");
    else check("drain_last", last_data_frame, 32'h100F100F);
    check("drained_level", 32'(LEVEL), 32'h0);

    // Reset mid-frame at B=20 with 5 words queued; writes during reset ignored
    n = fetches;
    cnt = 0;
    while (fetches == n && cnt < 300) begin step(); cnt++; end
    for (int i = 0; i < 5; i++) push_word(16'h2000 + 16'(i));
    cnt = 0;
    while (bcnt != 20 && cnt < 300) begin step(); cnt++; end
    if (bcnt != 20) timeout_fail("b20_sync");
    check("level_before_reset", 32'(LEVEL), 32'd5);
    RESET      = 1'b1;
    FIFO_WRITE = 1'b1;
    AUDIO_IN   = 16'h3333;
    step();
    RESET      = 1'b0;
    FIFO_WRITE = 1'b0;
    check("reset_mid_frame", 32'({SCLK, LRCLK, SDATA, UNDERRUN, FIFO_FULL, LEVEL}), 32'h0);
    cnt = 0;
    while (!SCLK && cnt < 50) begin step(); cnt++; end
    check("first_rise_after_reset", cnt, SCLK_DIV);

    // Held sample is cleared by reset: silence afterwards
    n = all_frames;
    cnt = 0;
    while (all_frames < n + 2 && cnt < 600) begin step(); cnt++; end
    if (all_frames < n + 2) timeout_fail("post_reset_wait");
    else check("post_reset_frame", last_frame, 32'h0);
    check("post_reset_level", 32'(LEVEL), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
